// File: rtl/fp32_mul_sequencer.sv
// fp32_mul_sequencer: FP32 multiply front/back end around a 24-bit sequential
// mantissa multiplier. It decodes the operands, resolves special values, and
// computes the sign and exponent. It launches the multiplier with hidden-bit
// mantissas, then normalizes and packs the product.
// Optional feature: define FP_MUL_TIMEOUT_EN to abort a WAIT that outlasts
// TIMEOUT_CYC cycles. The abort returns a quiet NaN and sets the timeout flag.
module fp32_mul_sequencer #(
  parameter int BIAS        = 127,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_opA,
  input  logic [31:0] i_opB,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_out_result,
  output logic [3:0]  o_flags,
  output logic        o_startMul,
  output logic [23:0] o_mulA,
  output logic [23:0] o_mulB,
  input  logic [23:0] i_mulResult,
  input  logic        i_doneMul
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_START, S_WAIT, S_NORM, S_DONE} state_t;

  state_t             r_state, w_nextState;
  logic [31:0]        r_opA, r_opB;
  logic [23:0]        r_mulA, r_mulB;
  logic signed [9:0]  r_expSum;
  logic [31:0]        r_result;
  logic [2:0]         r_flags;

  logic [7:0]         w_expA, w_expB;
  logic               w_sign, w_zeroA, w_zeroB, w_infA, w_infB, w_nanA, w_nanB, w_special;
  logic signed [9:0]  w_expSum;
  logic [31:0]        w_specialResult;
  logic               w_specialInvalid;
  logic signed [9:0]  w_normExp;
  logic [22:0]        w_normFrac;
  logic               w_normOverflow, w_normUnderflow;
  logic [31:0]        w_normResult;
  logic               w_timeoutHit;

  // Operand decode: exponent 0 means zero (denormals are flushed), 255 means inf or NaN.
  assign w_expA    = r_opA[30:23];
  assign w_expB    = r_opB[30:23];
  assign w_sign    = r_opA[31] ^ r_opB[31];
  assign w_zeroA   = (w_expA == 8'd0);
  assign w_zeroB   = (w_expB == 8'd0);
  assign w_infA    = (w_expA == 8'hFF) && (r_opA[22:0] == 23'd0);
  assign w_infB    = (w_expB == 8'hFF) && (r_opB[22:0] == 23'd0);
  assign w_nanA    = (w_expA == 8'hFF) && (r_opA[22:0] != 23'd0);
  assign w_nanB    = (w_expB == 8'hFF) && (r_opB[22:0] != 23'd0);
  assign w_special = w_zeroA | w_zeroB | (w_expA == 8'hFF) | (w_expB == 8'hFF);
  assign w_expSum  = {2'b00, w_expA} + {2'b00, w_expB} - 10'(BIAS);

`ifdef FP_MUL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] r_timeoutCnt;
  logic             r_timeout;

  assign w_timeoutHit = (r_state == S_WAIT) && !i_doneMul &&
                        (r_timeoutCnt == CNT_W'(TIMEOUT_CYC - 1));
  assign o_flags      = {r_flags, r_timeout};

  // Count consecutive WAIT cycles; restarts from zero on every entry into WAIT.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                r_timeoutCnt <= '0;
    else if (r_state == S_WAIT) r_timeoutCnt <= r_timeoutCnt + 1'b1;
    else                       r_timeoutCnt <= '0;
  end
`else
  assign w_timeoutHit = 1'b0;
  assign o_flags      = {r_flags, 1'b0};
`endif

  assign o_mulA       = r_mulA;
  assign o_mulB       = r_mulB;
  assign o_out_result = r_result;

  // Special-value result: an invalid NaN takes priority over inf, and inf over zero.
  always_comb begin
    w_specialResult  = {w_sign, 31'd0};
    w_specialInvalid = 1'b0;
    if (w_nanA || w_nanB || (w_zeroA && w_infB) || (w_zeroB && w_infA)) begin
      w_specialResult  = 32'h7FC0_0000;
      w_specialInvalid = 1'b1;
    end else if (w_infA || w_infB) begin
      w_specialResult = {w_sign, 8'hFF, 23'd0};
    end
  end

  // Normalize the top 24 product bits, truncate, and saturate the exponent range.
  always_comb begin
    if (i_mulResult[23]) begin
      w_normExp  = r_expSum + 10'sd1;
      w_normFrac = i_mulResult[22:0];
    end else begin
      w_normExp  = r_expSum;
      w_normFrac = {i_mulResult[21:0], 1'b0};
    end
    w_normOverflow  = (w_normExp >= 10'sd255);
    w_normUnderflow = (w_normExp <= 10'sd0);
    if (w_normOverflow)       w_normResult = {w_sign, 8'hFF, 23'd0};
    else if (w_normUnderflow) w_normResult = {w_sign, 31'd0};
    else                      w_normResult = {w_sign, w_normExp[7:0], w_normFrac};
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state logic and handshake/start strobes decoded from the current state.
  always_comb begin
    w_nextState = r_state;
    o_in_ready  = (r_state == S_IDLE);
    o_out_valid = (r_state == S_DONE);
    o_startMul  = (r_state == S_START);
    case (r_state)
      S_IDLE:  if (i_in_valid) w_nextState = S_CHECK;
      S_CHECK: w_nextState = w_special ? S_DONE : S_START;
      S_START: w_nextState = S_WAIT;
      S_WAIT: begin
        if (i_doneMul)         w_nextState = S_NORM;
        else if (w_timeoutHit) w_nextState = S_DONE;
      end
      S_NORM:  w_nextState = S_DONE;
      S_DONE:  if (i_out_ready) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Datapath: capture operands, load the multiplier, and build the packed product and flags.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_opA    <= '0;
      r_opB    <= '0;
      r_mulA   <= '0;
      r_mulB   <= '0;
      r_expSum <= '0;
      r_result <= '0;
      r_flags  <= '0;
`ifdef FP_MUL_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_opA   <= i_opA;
            r_opB   <= i_opB;
            r_flags <= '0;
`ifdef FP_MUL_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
          end
        end
        S_CHECK: begin
          if (w_special) begin
            r_result   <= w_specialResult;
            r_flags[2] <= w_specialInvalid;
          end else begin
            r_mulA   <= {1'b1, r_opA[22:0]};
            r_mulB   <= {1'b1, r_opB[22:0]};
            r_expSum <= w_expSum;
          end
        end
        S_WAIT: begin
`ifdef FP_MUL_TIMEOUT_EN
          if (w_timeoutHit) begin
            r_result  <= 32'h7FC0_0000;
            r_timeout <= 1'b1;
          end
`endif
        end
        S_NORM: begin
          r_result   <= w_normResult;
          r_flags[1] <= w_normOverflow;
          r_flags[0] <= w_normUnderflow;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_mul_sequencer.sv
// tb_fp32_mul_sequencer: drives directed and random operand pairs into the
// sequencer. It plays the mantissa multiplier with a random done latency and
// compares every product, flag set and latency with an arithmetic reference model.
module tb_fp32_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [31:0] opA, opB;
  logic        outValid;
  logic        outReady;
  logic [31:0] outResult;
  logic [3:0]  flags;
  logic        startMul;
  logic [23:0] mulA, mulB;
  logic [23:0] mulResult;
  logic        doneMul;

  int errors = 0;
  int checks = 0;

  fp32_mul_sequencer dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (inValid),
    .o_in_ready  (inReady),
    .i_opA       (opA),
    .i_opB       (opB),
    .o_out_valid (outValid),
    .i_out_ready (outReady),
    .o_out_result(outResult),
    .o_flags     (flags),
    .o_startMul  (startMul),
    .o_mulA      (mulA),
    .o_mulB      (mulB),
    .i_mulResult (mulResult),
    .i_doneMul   (doneMul)
  );

  always #5 clk = ~clk;

  // Compare one observed value with its expected value and log a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  // Reference model: IEEE decode, exact 48-bit mantissa product, truncating normalization.
  function automatic void refModel(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] res, output logic [3:0] flg,
                                   output bit isSpecial);
    int ea = int'(a[30:23]);
    int eb = int'(b[30:23]);
    logic s = a[31] ^ b[31];
    bit zA = (ea == 0), zB = (eb == 0);
    bit iA = (ea == 255) && (a[22:0] == 0), iB = (eb == 255) && (b[22:0] == 0);
    bit nA = (ea == 255) && (a[22:0] != 0), nB = (eb == 255) && (b[22:0] != 0);
    longint unsigned p;
    int e;
    logic [22:0] frac;
    flg = 4'b0000;
    isSpecial = 1;
    if (nA || nB || (zA && iB) || (zB && iA)) begin
      res = 32'h7FC0_0000;
      flg = 4'b1000;
    end else if (iA || iB) begin
      res = {s, 31'h7F80_0000};
    end else if (zA || zB) begin
      res = {s, 31'd0};
    end else begin
      isSpecial = 0;
      p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
      e = ea + eb - 127;
      if (p >= (64'd1 << 47)) begin
        e = e + 1;
        frac = 23'((p >> 24) & 64'h7F_FFFF);
      end else begin
        frac = 23'(((p >> 24) & 64'h3F_FFFF) << 1);
      end
      if (e >= 255) begin
        res = {s, 31'h7F80_0000};
        flg = 4'b0100;
      end else if (e <= 0) begin
        res = {s, 31'd0};
        flg = 4'b0010;
      end else begin
        res = {s, 8'(e), frac};
      end
    end
  endfunction

  // Random operand biased toward specials and exponent extremes.
  function automatic logic [31:0] randOperand();
    logic s = 1'($urandom);
    logic [22:0] f = 23'($urandom);
    case ($urandom_range(0, 9))
      0:       return {s, 8'd0, f};
      1:       return {s, 8'hFF, 23'd0};
      2:       return {s, 8'hFF, f | 23'd1};
      3:       return {s, 8'($urandom_range(200, 254)), f};
      4:       return {s, 8'($urandom_range(1, 50)), f};
      default: return {s, 8'($urandom_range(100, 154)), f};
    endcase
  endfunction

  // Run one transaction while acting as the multiplier; doneDelay<0 means done never comes.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input int doneDelay, input int holdCycles);
    logic [31:0] expRes;
    logic [3:0]  expFlg;
    bit          isSp;
    logic [47:0] prod;
    int n = 0, startCnt = 0, startNeg = -1, doneNeg = -1, outNeg = -1;
    refModel(a, b, expRes, expFlg, isSp);
    if (doneDelay < 0) begin
      expRes = 32'h7FC0_0000;
      expFlg = 4'b0001;
    end
    @(negedge clk);
    checkOutput("inReadyIdle", 32'(inReady), 32'd1);
    opA = a;
    opB = b;
    inValid = 1'b1;
    @(negedge clk);
    n = 1;
    checkOutput("inReadyBusy", 32'(inReady), 32'd0);
    while (outNeg < 0 && n < 400) begin
      if (startMul) begin
        startCnt++;
        if (startNeg < 0) begin
          startNeg = n;
          checkOutput("mulA", 32'(mulA), 32'({1'b1, a[22:0]}));
          checkOutput("mulB", 32'(mulB), 32'({1'b1, b[22:0]}));
        end
      end
      if (outValid) begin
        outNeg = n;
        inValid = 1'b0;
      end else begin
        inValid = 1'($urandom);
        opA = $urandom;
        opB = $urandom;
        if (startNeg >= 0 && n > startNeg && doneNeg < 0) begin
          if (doneDelay >= 0 && n - startNeg - 1 == doneDelay) begin
            checkOutput("mulAHeld", 32'(mulA), 32'({1'b1, a[22:0]}));
            prod = 48'(mulA) * 48'(mulB);
            mulResult = prod[47:24];
            doneMul = 1'b1;
            doneNeg = n;
          end else begin
            mulResult = 24'($urandom);
            doneMul = 1'b0;
          end
        end
        @(negedge clk);
        n++;
      end
    end
    if (outNeg < 0) begin
      checkOutput("outValidSeen", 32'd0, 32'd1);
    end else begin
      checkOutput("result", outResult, expRes);
      checkOutput("flags", 32'(flags), 32'(expFlg));
      checkOutput("startCount", 32'(startCnt), (isSp && doneDelay >= 0) ? 32'd0 : 32'd1);
      if (doneDelay < 0)  checkOutput("latencyTimeout", 32'(outNeg - startNeg), 32'd65);
      else if (isSp)      checkOutput("latencySpecial", 32'(outNeg), 32'd2);
      else                checkOutput("latencyNormal", 32'(outNeg - doneNeg), 32'd2);
      if (holdCycles > 0) begin
        repeat (holdCycles) @(negedge clk);
        checkOutput("holdValid", 32'(outValid), 32'd1);
        checkOutput("holdResult", outResult, expRes);
        checkOutput("holdInReady", 32'(inReady), 32'd0);
      end
      outReady = 1'b1;
      @(negedge clk);
      outReady = 1'b0;
      checkOutput("releaseValid", 32'(outValid), 32'd0);
      checkOutput("releaseInReady", 32'(inReady), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b0;
    inValid = 1'b0;
    outReady = 1'b0;
    opA = '0;
    opB = '0;
    doneMul = 1'b1;
    mulResult = 24'($urandom);
    repeat (3) @(negedge clk);
    checkOutput("rstInReady", 32'(inReady), 32'd1);
    checkOutput("rstOutValid", 32'(outValid), 32'd0);
    checkOutput("rstStart", 32'(startMul), 32'd0);
    checkOutput("rstMulA", 32'(mulA), 32'd0);
    checkOutput("rstMulB", 32'(mulB), 32'd0);
    checkOutput("rstResult", outResult, 32'd0);
    checkOutput("rstFlags", 32'(flags), 32'd0);
    rst = 1'b1;

    $display("[TB] directed operand pairs");
    applyStimulus(32'h4000_0000, 32'h4040_0000, 2, 0);
    applyStimulus(32'h3FC0_0000, 32'h3FC0_0000, 0, 0);
    applyStimulus(32'hC000_0000, 32'h4040_0000, 3, 5);
    applyStimulus(32'h0000_0000, 32'h7F80_0000, 1, 0);
    applyStimulus(32'h7F00_0000, 32'h7F00_0000, 1, 0);
    applyStimulus(32'h0080_0000, 32'h0080_0000, 4, 0);
    applyStimulus(32'h7F80_0000, 32'hBF80_0000, 0, 1);
    applyStimulus(32'h7FC1_2345, 32'h3F80_0000, 0, 0);

    $display("[TB] random operand pairs");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(randOperand(), randOperand(), $urandom_range(0, 5), $urandom_range(0, 2));
    end

    $display("[TB] reset during WAIT");
    @(negedge clk);
    opA = 32'h4000_0000;
    opB = 32'h4040_0000;
    inValid = 1'b1;
    doneMul = 1'b0;
    @(negedge clk);
    inValid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("midRstOutValid", 32'(outValid), 32'd0);
    checkOutput("midRstInReady", 32'(inReady), 32'd1);
    checkOutput("midRstStart", 32'(startMul), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(32'h3FC0_0000, 32'h4000_0000, 1, 0);

`ifdef FP_MUL_TIMEOUT_EN
    $display("[TB] multiplier never finishes");
    applyStimulus(32'h4000_0000, 32'h4040_0000, -1, 0);
    applyStimulus(32'h4000_0000, 32'h4040_0000, 2, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
